alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 Port: reqN_ready  output  1  (N=0,1) request N accepted this cycle.
REQ-006 Port: reqN_op  input  5  (N=0,1) ALU opcode, same 5-bit encoding as the shared ALU.
REQ-007 Port: reqN_a, reqN_b  input  32  (N=0,1) operands.
REQ-008 Port: rspN_valid  output  1  (N=0,1) response for requester N available.
REQ-009 Port: rspN_ready  input  1  (N=0,1) requester N consumes the response.
REQ-010 Port: rspN_result  output  32; rspN_zero, rspN_overflow  output  1  (N=0,1) captured ALU outputs.
REQ-011 Port: alu_op  output  5; alu_a, alu_b  output  32  drive the shared combinational ALU.
REQ-012 Port: alu_result  input  32; alu_zero, alu_overflow  input  1  shared ALU outputs.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block shall implement states IDLE, EXEC and RESP, one transaction in flight at a time.
REQ-015 In IDLE, if any reqN_valid is high, the block shall grant exactly one requester, assert its reqN_ready combinationally for that cycle, latch its op/a/b into operand registers, record the grant id and go to EXEC.
REQ-016 reqN_ready shall be high only in IDLE, only for the granted requester, and never for both in the same cycle.
REQ-017 With RR_EN=1 and both valid, the grant shall go to the requester not granted last; with only one valid it goes to that one; last-grant updates only on acceptance.
REQ-018 With RR_EN=0 and both valid, requester 0 shall always win.
REQ-019 alu_op/alu_a/alu_b shall be driven from the operand registers (registered, glitch-free), holding their values outside EXEC.
REQ-020 In EXEC (one cycle) the block shall capture alu_result, alu_zero, alu_overflow into the response registers of the granted id and go to RESP.
REQ-021 In RESP, rspN_valid of the granted id shall be high, its result/zero/overflow stable, and the other rspN_valid low.
REQ-022 On rspN_valid and rspN_ready both high, the block shall return to IDLE next cycle; no new request is accepted in that same cycle.
REQ-023 Latency: rspN_valid rises exactly 2 cycles after the accepting edge; minimum initiation interval is 3 cycles.
REQ-024 While rspN_ready is low, response and all reqN_ready shall hold (full backpressure, no drop, no overwrite).
REQ-025 Requesters hold valid and payload until ready; payload changes after acceptance shall not affect the in-flight operation.
REQ-026 rspN_ready asserted while rspN_valid is low shall be ignored.
REQ-027 The block shall not reinterpret opcodes or widths; results pass 32 bits unmodified.

Reset
REQ-028 resetn low shall immediately force IDLE, busy=0, reqN_ready=0, rspN_valid=0, rspN_result=0, rspN_zero=0, rspN_overflow=0, alu_op=0, alu_a=0, alu_b=0, last-grant=1 (requester 0 wins first under RR).
REQ-029 Reset in EXEC or RESP shall discard the in-flight transaction; no response is produced for it after release.
REQ-030 After resetn deasserts, the first acceptance shall occur no earlier than the first rising edge with resetn high.

Verification
REQ-031 req0 op=10001 a=5 b=7, rsp0_ready=1 -> req0_ready 1 cycle, rsp0_valid 2 cycles later, result=12, zero=0, overflow=0.
REQ-032 req1 op=10010 a=5 b=5 -> rsp1_result=0, rsp1_zero=1, rsp0_valid stays 0.
REQ-033 Both valid continuously after reset, RR_EN=1 -> grant order 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-034 req0 op=10000 a=0x7FFFFFFF b=1 -> rsp0_result=0x80000000, rsp0_overflow=1.
REQ-035 rsp0_ready low 5 cycles during RESP, req1_valid high -> rsp0 outputs stable, req1_ready=0, busy=1 until handshake; req1 then accepted.
REQ-036 resetn pulsed low during EXEC of req0 -> all outputs 0 at once; no rsp0_valid after release.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-requester front end for one shared combinational ALU: IDLE grants one
// request, EXEC captures the ALU outputs, RESP holds the response until consumed.
module alu_share_arb #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zero,
   output logic        rsp0_overflow,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zero,
   output logic        rsp1_overflow,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state;
   logic   gid;
   logic   last;
   logic   gnt_any;
   logic   gnt_id;
   logic   rsp_hs;

   // Grant is only offered while out of reset so nothing is accepted before
   // the first rising edge with resetn high.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (state == IDLE && resetn) begin
         gnt_any = req0_valid | req1_valid;
         if (req0_valid && req1_valid)
            gnt_id = (RR_EN != 0) ? ~last : 1'b0;
         else
            gnt_id = req1_valid;
      end
   end

   assign req0_ready = gnt_any & ~gnt_id;
   assign req1_ready = gnt_any &  gnt_id;
   assign rsp0_valid = (state == RESP) & ~gid;
   assign rsp1_valid = (state == RESP) &  gid;
   assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         gid           <= 1'b0;
         last          <= 1'b1;
         alu_op        <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         rsp0_result   <= '0;
         rsp0_zero     <= 1'b0;
         rsp0_overflow <= 1'b0;
         rsp1_result   <= '0;
         rsp1_zero     <= 1'b0;
         rsp1_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  alu_op <= gnt_id ? req1_op : req0_op;
                  alu_a  <= gnt_id ? req1_a  : req0_a;
                  alu_b  <= gnt_id ? req1_b  : req0_b;
                  gid    <= gnt_id;
                  last   <= gnt_id;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (gid) begin
                  rsp1_result   <= alu_result;
                  rsp1_zero     <= alu_zero;
                  rsp1_overflow <= alu_overflow;
               end else begin
                  rsp0_result   <= alu_result;
                  rsp0_zero     <= alu_zero;
                  rsp0_overflow <= alu_overflow;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_hs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: round-robin instance plus a fixed-priority
// instance, each fed by a small reference ALU.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_ready, rsp1_ready;

   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp0_overflow, rsp1_zero, rsp1_overflow;
   logic [4:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero, alu_overflow;

   logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
   logic [31:0] fp_rsp0_result, fp_rsp1_result;
   logic        fp_rsp0_zero, fp_rsp0_overflow, fp_rsp1_zero, fp_rsp1_overflow;
   logic [4:0]  fp_alu_op;
   logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result;
   logic        fp_alu_zero, fp_alu_overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [33:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic        o;
      r = '0;
      o = 1'b0;
      case (op)
         5'b10000, 5'b10001: begin
            r = a + b;
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b10010: begin
            r = a - b;
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         default: r = a & b;
      endcase
      return {o, (r == 32'd0), r};
   endfunction

   always_comb {alu_overflow, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);
   always_comb {fp_alu_overflow, fp_alu_zero, fp_alu_result} = alu_f(fp_alu_op, fp_alu_a, fp_alu_b);

   alu_share_arb #(.RR_EN(1)) dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .busy(busy)
   );

   alu_share_arb #(.RR_EN(0)) dut_fp (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(fp_rsp0_result),
      .rsp0_zero(fp_rsp0_zero), .rsp0_overflow(fp_rsp0_overflow),
      .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(fp_rsp1_result),
      .rsp1_zero(fp_rsp1_zero), .rsp1_overflow(fp_rsp1_overflow),
      .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
      .alu_result(fp_alu_result), .alu_zero(fp_alu_zero), .alu_overflow(fp_alu_overflow),
      .busy(fp_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction with rsp ready held high; called at a negedge+1 in IDLE.
   task automatic txn(input string tag, input bit id, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ez, input logic eo);
      @(negedge clk);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; rsp1_ready = 1'b1;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; rsp0_ready = 1'b1;
      end
      #1;
      chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
      chk({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
      #1;
      chk({tag, "_exec_busy"}, busy, 1);
      chk({tag, "_exec_rspv"}, id ? rsp1_valid : rsp0_valid, 0);
      chk({tag, "_alu_a"}, alu_a, a);
      @(negedge clk); #1;
      chk({tag, "_rspv"}, id ? rsp1_valid : rsp0_valid, 1);
      chk({tag, "_other_rspv"}, id ? rsp0_valid : rsp1_valid, 0);
      chk({tag, "_result"}, id ? rsp1_result : rsp0_result, er);
      chk({tag, "_zero"}, id ? rsp1_zero : rsp0_zero, ez);
      chk({tag, "_ovf"}, id ? rsp1_overflow : rsp0_overflow, eo);
      @(negedge clk); #1;
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_rspv"}, id ? rsp1_valid : rsp0_valid, 0);
      chk({tag, "_alu_hold"}, alu_a, a);
   endtask

   initial begin
      int n;
      resetn = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // reset state, with a request pending that must not be taken
      repeat (2) @(negedge clk);
      req0_valid = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_rsp1_result", rsp1_result, 0);
      req0_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;

      txn("add", 1'b0, 5'b10001, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      txn("sub", 1'b1, 5'b10010, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
      txn("ovf", 1'b0, 5'b10000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);

      // backpressure on rsp0 while req1 waits
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'b10001; req0_a = 32'd100; req0_b = 32'd23;
      rsp0_ready = 1'b0;
      #1;
      chk("bp_req0_ready", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 5'b10001; req1_a = 32'd1; req1_b = 32'd2; rsp1_ready = 1'b1;
      #1;
      chk("bp_exec_req1_ready", req1_ready, 0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_rsp0_valid", rsp0_valid, 1);
         chk("bp_rsp0_result", rsp0_result, 32'd123);
         chk("bp_req1_ready", req1_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      #1;
      chk("bp_hs_req1_ready", req1_ready, 0);
      chk("bp_hs_rsp0_valid", rsp0_valid, 1);
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      chk("bp_after_rsp0_valid", rsp0_valid, 0);
      chk("bp_after_req1_ready", req1_ready, 1);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_result", rsp1_result, 32'd3);
      @(negedge clk); #1;
      chk("bp_end_busy", busy, 0);

      // reset pulse during EXEC discards the transaction
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'b10001; req0_a = 32'd9; req0_b = 32'd9; rsp0_ready = 1'b1;
      #1;
      chk("rx_req0_ready", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      chk("rx_exec_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("rx_busy", busy, 0);
      chk("rx_rsp0_result", rsp0_result, 0);
      chk("rx_alu_a", alu_a, 0);
      chk("rx_alu_op", alu_op, 0);
      chk("rx_rsp0_valid", rsp0_valid, 0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("rx_post_rsp0_valid", rsp0_valid, 0);
         chk("rx_post_busy", busy, 0);
      end

      // both valid continuously after reset: RR 0,1,0,1 ; fixed 0,0,0,0
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'b10001; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_op = 5'b10001; req1_a = 32'd2; req1_b = 32'd2;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         #1;
         while (!(req0_ready || req1_ready) && n < 10) begin
            @(negedge clk); #1;
            n++;
         end
         chk("gnt_timeout", (n < 10), 1);
         chk("gnt_rr_id", req1_ready, k % 2);
         chk("gnt_rr_excl", req0_ready & req1_ready, 0);
         chk("gnt_fp_req0", fp_req0_ready, 1);
         chk("gnt_fp_req1", fp_req1_ready, 0);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
